// File: rtl/mem_if_pkg.sv
// Shared types and constants for the data memory interface: FSM states,
// access-size encodings, the default timeout and the alignment rule.
package mem_if_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int TIMEOUT_CYC_DEF = 16;

  // The reserved size 2'b11 is treated as a word access.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: is_aligned = 1'b1;
      SZ_HALF: is_aligned = ~off[0];
      default: is_aligned = (off == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/data_mem_if_if.sv
// Memory-side bus of data_mem_if.
// The master drives the request; the slave returns read data and the acknowledge.
interface data_mem_if_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational big-endian lane logic: generates byte enables, replicates store
// data, and extracts and extends load data (offset 0 is bits 31:24).
module mem_lane_align
  import mem_if_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] load_data,
  output logic        aligned
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection, byte enables, store replication and load extension
  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata;
    load_data = mem_rdata;
    aligned   = is_aligned(size, off);

    case (off)
      2'd0:    byte_s = mem_rdata[31:24];
      2'd1:    byte_s = mem_rdata[23:16];
      2'd2:    byte_s = mem_rdata[15:8];
      default: byte_s = mem_rdata[7:0];
    endcase

    if (off[1]) begin
      half_s = mem_rdata[15:0];
    end else begin
      half_s = mem_rdata[31:16];
    end

    case (size)
      SZ_BYTE: begin
        be        = 4'b1000 >> off;
        wdata_rep = {4{wdata[7:0]}};
        if (uns) begin
          load_data = {24'h000000, byte_s};
        end else begin
          load_data = {{24{byte_s[7]}}, byte_s};
        end
      end
      SZ_HALF: begin
        if (off[1]) begin
          be = 4'b0011;
        end else begin
          be = 4'b1100;
        end
        wdata_rep = {2{wdata[15:0]}};
        if (uns) begin
          load_data = {16'h0000, half_s};
        end else begin
          load_data = {{16{half_s[15]}}, half_s};
        end
      end
      default: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        load_data = mem_rdata;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_if.sv
// Load/store unit between the integer datapath and a data memory.
// Optional no-ack timeout is enabled with the MEM_TIMEOUT_EN macro.
module data_mem_if
  import mem_if_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        st,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        addr_err,
  output logic        timeout_err,
  data_mem_if_if.master mem
);

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("data_mem_if: TIMEOUT_CYC out of range 2..255");
  end

  state_t      state_r, state_nx_s;
  logic [1:0]  size_r, off_r;
  logic        uns_r;
  logic [1:0]  al_size_s, al_off_s;
  logic        al_uns_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_rep_s, load_data_s;
  logic        aligned_s;
  logic        accept_s, ack_s, tmo_s, err_s, limit_s;

  // The lane logic sees the live request in IDLE and the latched one afterwards
  always_comb begin
    if (state_r == ST_IDLE) begin
      al_size_s = size;
      al_off_s  = addr[1:0];
      al_uns_s  = uns;
    end else begin
      al_size_s = size_r;
      al_off_s  = off_r;
      al_uns_s  = uns_r;
    end
  end

  mem_lane_align u_align (
    .size      (al_size_s),
    .off       (al_off_s),
    .uns       (al_uns_s),
    .wdata     (wdata),
    .mem_rdata (mem.mem_rdata),
    .be        (be_s),
    .wdata_rep (wdata_rep_s),
    .load_data (load_data_s),
    .aligned   (aligned_s)
  );

`ifdef MEM_TIMEOUT_EN
  logic [7:0] cnt_r;
  assign limit_s = (cnt_r == 8'(TIMEOUT_CYC - 1));

  // Wait counter: zero outside REQ, so it starts from zero on every REQ entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= 8'd0;
    end else if (state_r != ST_REQ) begin
      cnt_r <= 8'd0;
    end else begin
      cnt_r <= cnt_r + 8'd1;
    end
  end
`else
  assign limit_s = 1'b0;
`endif

  // Next-state logic; an ack on the limit cycle wins over the timeout
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    ack_s      = 1'b0;
    tmo_s      = 1'b0;
    err_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (aligned_s) begin
            state_nx_s = ST_REQ;
            accept_s   = 1'b1;
          end else begin
            state_nx_s = ST_DONE;
            err_s      = 1'b1;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mem.mem_ack) begin
          state_nx_s = ST_DONE;
          ack_s      = 1'b1;
        end else if (limit_s) begin
          state_nx_s = ST_DONE;
          tmo_s      = 1'b1;
        end else begin
          state_nx_s = ST_REQ;
        end
      end
      ST_DONE: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Registered outputs and the latched request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      addr_err      <= 1'b0;
      timeout_err   <= 1'b0;
      rdata         <= 32'h0000_0000;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= 32'h0000_0000;
      mem.mem_be    <= 4'b0000;
      mem.mem_wdata <= 32'h0000_0000;
      size_r        <= 2'b00;
      off_r         <= 2'b00;
      uns_r         <= 1'b0;
    end else begin
      busy        <= (state_nx_s != ST_IDLE);
      done        <= (state_nx_s == ST_DONE);
      mem.mem_req <= (state_nx_s == ST_REQ);
      addr_err    <= err_s;
      timeout_err <= tmo_s;
      if (accept_s) begin
        mem.mem_we    <= st;
        mem.mem_addr  <= {addr[31:2], 2'b00};
        mem.mem_be    <= be_s;
        mem.mem_wdata <= wdata_rep_s;
        size_r        <= size;
        off_r         <= addr[1:0];
        uns_r         <= uns;
      end
      if (ack_s && !mem.mem_we) begin
        rdata <= load_data_s;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_if.sv
// Directed, table-driven bench for data_mem_if (TIMEOUT_CYC=4), with
// hand-written sequences for reset, ignored inputs and the timeout path.
module tb_data_mem_if;
  import mem_if_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        st = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        uns = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        busy, done, addr_err, timeout_err;
  logic [31:0] rdata;

  data_mem_if_if mem ();

  data_mem_if #(.TIMEOUT_CYC(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .st          (st),
    .size        (size),
    .uns         (uns),
    .addr        (addr),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .rdata       (rdata),
    .addr_err    (addr_err),
    .timeout_err (timeout_err),
    .mem         (mem)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        st;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrd;
    int          ack_cyc;
    logic [3:0]  be;
    logic [31:0] mwd;
    logic [31:0] rd;
    logic        aerr;
  } vec_t;

  vec_t        vt[13];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_rdata = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    start = 1'b1; st = v.st; size = v.size; uns = v.uns; addr = v.addr; wdata = v.wdata;
    tick();
    start = 1'b0;
    if (v.aerr) begin
      check({v.name, " done"}, 32'(done), 32'd1);
      check({v.name, " addr_err"}, 32'(addr_err), 32'd1);
      check({v.name, " mem_req"}, 32'(mem.mem_req), 32'd0);
      check({v.name, " rdata"}, rdata, exp_rdata);
      tick();
      check({v.name, " done_low"}, 32'(done), 32'd0);
      check({v.name, " addr_err_low"}, 32'(addr_err), 32'd0);
      check({v.name, " idle"}, 32'(busy), 32'd0);
    end else begin
      check({v.name, " mem_req"}, 32'(mem.mem_req), 32'd1);
      check({v.name, " mem_we"}, 32'(mem.mem_we), 32'(v.st));
      check({v.name, " mem_be"}, 32'(mem.mem_be), 32'(v.be));
      check({v.name, " mem_addr"}, mem.mem_addr, {v.addr[31:2], 2'b00});
      check({v.name, " mem_wdata"}, mem.mem_wdata, v.mwd);
      for (int c = 1; c < v.ack_cyc; c++) begin
        tick();
        check({v.name, " mem_req_hold"}, 32'(mem.mem_req), 32'd1);
        check({v.name, " done_early"}, 32'(done), 32'd0);
      end
      mem.mem_rdata = v.mrd;
      mem.mem_ack = 1'b1;
      tick();
      mem.mem_ack = 1'b0;
      if (!v.st) exp_rdata = v.rd;
      check({v.name, " done"}, 32'(done), 32'd1);
      check({v.name, " addr_err"}, 32'(addr_err), 32'd0);
      check({v.name, " timeout_err"}, 32'(timeout_err), 32'd0);
      check({v.name, " mem_req_drop"}, 32'(mem.mem_req), 32'd0);
      check({v.name, " rdata"}, rdata, exp_rdata);
      tick();
      check({v.name, " done_low"}, 32'(done), 32'd0);
      check({v.name, " idle"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected end within 200000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //          name        st size   uns addr          wdata         mem_rdata     ack be       mem_wdata     rdata         aerr
    vt[0]  = '{"lb_1003",  1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_0000, 32'h1122_3380, 3, 4'b0001, 32'h0000_0000, 32'hFFFF_FF80, 1'b0};
    vt[1]  = '{"lhu_2002", 1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0000_0000, 32'hAAAA_8001, 1, 4'b0011, 32'h0000_0000, 32'h0000_8001, 1'b0};
    vt[2]  = '{"sb_10",    1'b1, 2'b00, 1'b0, 32'h0000_0010, 32'h0000_00A5, 32'h0000_0000, 1, 4'b1000, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0};
    vt[3]  = '{"lh_2000",  1'b0, 2'b01, 1'b0, 32'h0000_2000, 32'h0000_0000, 32'h8001_AAAA, 1, 4'b1100, 32'h0000_0000, 32'hFFFF_8001, 1'b0};
    vt[4]  = '{"lbu_1001", 1'b0, 2'b00, 1'b1, 32'h0000_1001, 32'h0000_0000, 32'h11F2_3344, 1, 4'b0100, 32'h0000_0000, 32'h0000_00F2, 1'b0};
    vt[5]  = '{"sh_2002",  1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h1234_BEEF, 32'h0000_0000, 2, 4'b0011, 32'hBEEF_BEEF, 32'h0000_0000, 1'b0};
    vt[6]  = '{"lw_3000",  1'b0, 2'b10, 1'b0, 32'h0000_3000, 32'h0000_0000, 32'hDEAD_BEEF, 1, 4'b1111, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vt[7]  = '{"l11_4004", 1'b0, 2'b11, 1'b0, 32'h0000_4004, 32'h0000_0000, 32'hCAFE_F00D, 1, 4'b1111, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};
    vt[8]  = '{"lw_6",     1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0000_0000, 32'h0000_0000, 1, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vt[9]  = '{"lh_2001",  1'b0, 2'b01, 1'b0, 32'h0000_2001, 32'h0000_0000, 32'h0000_0000, 1, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vt[10] = '{"sw_5000",  1'b1, 2'b10, 1'b0, 32'h0000_5000, 32'h0123_4567, 32'h0000_0000, 2, 4'b1111, 32'h0123_4567, 32'h0000_0000, 1'b0};
    vt[11] = '{"lb_1000",  1'b0, 2'b00, 1'b0, 32'h0000_1000, 32'h0000_0000, 32'h7F00_0000, 1, 4'b1000, 32'h0000_0000, 32'h0000_007F, 1'b0};
    vt[12] = '{"lw_c000",  1'b0, 2'b10, 1'b0, 32'h0000_C000, 32'h0000_0000, 32'h600D_CAFE, 4, 4'b1111, 32'h0000_0000, 32'h600D_CAFE, 1'b0};

    mem.mem_ack = 1'b0;
    mem.mem_rdata = 32'h0;

    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset rdata", rdata, 32'h0);
    check("reset mem_req", 32'(mem.mem_req), 32'd0);
    check("reset mem_be", 32'(mem.mem_be), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) run_vec(vt[i]);

    // mem_ack outside REQ is ignored
    mem.mem_ack = 1'b1;
    tick();
    mem.mem_ack = 1'b0;
    check("stray_ack busy", 32'(busy), 32'd0);
    check("stray_ack done", 32'(done), 32'd0);

    // start while busy is ignored, both in REQ and in DONE
    start = 1'b1; st = 1'b0; size = SZ_WORD; uns = 1'b0; addr = 32'h0000_8000; wdata = 32'h0;
    tick();
    st = 1'b1; addr = 32'h0000_9004;
    tick();
    start = 1'b0;
    check("busy_start mem_addr", mem.mem_addr, 32'h0000_8000);
    check("busy_start mem_we", 32'(mem.mem_we), 32'd0);
    mem.mem_rdata = 32'h1357_2468;
    mem.mem_ack = 1'b1;
    tick();
    mem.mem_ack = 1'b0;
    exp_rdata = 32'h1357_2468;
    check("busy_start done", 32'(done), 32'd1);
    check("busy_start rdata", rdata, exp_rdata);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("done_start idle", 32'(busy), 32'd0);
    check("done_start mem_req", 32'(mem.mem_req), 32'd0);
    tick();

`ifdef MEM_TIMEOUT_EN
    // No ack: mem_req high for exactly 4 cycles, then a timeout completion
    start = 1'b1; st = 1'b0; size = SZ_WORD; addr = 32'h0000_D000;
    tick();
    start = 1'b0;
    check("tmo mem_req c1", 32'(mem.mem_req), 32'd1);
    for (int c = 2; c <= 4; c++) begin
      tick();
      check("tmo mem_req hold", 32'(mem.mem_req), 32'd1);
      check("tmo done early", 32'(done), 32'd0);
    end
    tick();
    check("tmo done", 32'(done), 32'd1);
    check("tmo timeout_err", 32'(timeout_err), 32'd1);
    check("tmo addr_err", 32'(addr_err), 32'd0);
    check("tmo mem_req drop", 32'(mem.mem_req), 32'd0);
    check("tmo rdata", rdata, exp_rdata);
    tick();
    check("tmo timeout_err low", 32'(timeout_err), 32'd0);
    check("tmo idle", 32'(busy), 32'd0);
`else
    // Without the timeout, REQ waits for as long as the ack takes
    start = 1'b1; st = 1'b0; size = SZ_WORD; addr = 32'h0000_D000;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      check("wait mem_req hold", 32'(mem.mem_req), 32'd1);
      check("wait done low", 32'(done), 32'd0);
      tick();
    end
    mem.mem_rdata = 32'h2468_ACE0;
    mem.mem_ack = 1'b1;
    tick();
    mem.mem_ack = 1'b0;
    exp_rdata = 32'h2468_ACE0;
    check("wait done", 32'(done), 32'd1);
    check("wait timeout_err", 32'(timeout_err), 32'd0);
    check("wait rdata", rdata, exp_rdata);
    tick();
`endif

    // Reset in REQ aborts at once, with no clock edge and no done pulse
    start = 1'b1; st = 1'b0; size = SZ_WORD; addr = 32'h0000_A000;
    tick();
    start = 1'b0;
    check("rst_req mem_req before", 32'(mem.mem_req), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("rst_req mem_req async", 32'(mem.mem_req), 32'd0);
    check("rst_req busy", 32'(busy), 32'd0);
    check("rst_req rdata", rdata, 32'h0);
    exp_rdata = 32'h0;
    tick();
    check("rst_req no done", 32'(done), 32'd0);
    reset = 1'b1;
    tick();
    check("rst_rel no done", 32'(done), 32'd0);
    run_vec('{"lw_b000", 1'b0, 2'b10, 1'b0, 32'h0000_B000, 32'h0000_0000, 32'h0BAD_F00D, 2,
              4'b1111, 32'h0000_0000, 32'h0BAD_F00D, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_if.md
DATA_MEM_IF -- requirements
Module: data_mem_if

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16: maximum number of REQ-state cycles to wait for mem_ack; legal range 2..255.
REQ-002 clk  input  1  rising-edge system clock, shared with the integer datapath.
REQ-003 reset  input  1  asynchronous, active-low reset; the block is in reset while reset=0.
REQ-004 start  input  1  one-cycle request from control; sampled only in IDLE.
REQ-005 st  input  1  1=store, 0=load; sampled with start.
REQ-006 size  input  2  00=byte, 01=half, 10=word; 11 is reserved and treated as word; sampled with start.
REQ-007 uns  input  1  1=zero-extend a load, 0=sign-extend; sampled with start.
REQ-008 addr  input  32  byte address from the ALU output register; sampled with start.
REQ-009 wdata  input  32  store data from the RT register; sampled with start.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 rdata  output  32  registered, aligned and extended load result; feeds the datapath DY input.
REQ-013 addr_err  output  1  misaligned access flag, valid while done=1.
REQ-014 timeout_err  output  1  no-ack flag, valid while done=1.
REQ-015 mem_req, mem_we  output  1 each  memory request and write enable.
REQ-016 mem_addr  output  32  word address {addr[31:2],2'b00}; mem_be output 4; mem_wdata output 32.
REQ-017 mem_rdata  input  32; mem_ack  input  1  memory read data and acknowledge.

Function
REQ-018 FSM states are IDLE, REQ, DONE. IDLE+start goes to REQ if aligned, else to DONE with addr_err=1. REQ+mem_ack goes to DONE. DONE always returns to IDLE.
REQ-019 Alignment: half requires addr[0]=0; word requires addr[1:0]=00. A misaligned access never asserts mem_req and leaves rdata unchanged.
REQ-020 Latency: start at cycle 0 gives mem_req=1 at cycle 1. mem_ack at cycle k gives done=1 at cycle k+1. A misaligned access gives done at cycle 1.
REQ-021 mem_req stays high from REQ entry through the ack cycle. mem_addr, mem_we, mem_be and mem_wdata are registered and stay stable for that whole interval.
REQ-022 The block ignores start outside IDLE and ignores mem_ack outside REQ.
REQ-023 Byte lanes are big-endian: address offset 0 maps to bits 31:24 and to mem_be[3].
REQ-024 mem_be: byte gives 4'b1000 shifted right by addr[1:0]; half gives 1100 (offset 0) or 0011 (offset 2); word gives 1111. Loads drive the same mem_be.
REQ-025 Store data: byte is replicated {4{wdata[7:0]}}, half is {2{wdata[15:0]}}, word is wdata.
REQ-026 Loads select the addressed lane from mem_rdata on the ack cycle, extend it per uns, and register the result into rdata. rdata holds until the next successful load.
REQ-027 addr_err and timeout_err are low whenever done=0.

Reset
REQ-028 On reset=0, asynchronously: state goes to IDLE and every output goes to 0, including rdata and mem_req.
REQ-029 Reset during REQ aborts the access immediately and produces no done pulse. The first start after reset release is accepted normally.

Configuration
REQ-030 Macro MEM_TIMEOUT_EN.
- Defined: an 8-bit counter clears on REQ entry and increments each REQ cycle without ack. At TIMEOUT_CYC the block drops mem_req, moves to DONE with timeout_err=1, and leaves rdata unchanged. An ack in the same cycle as the limit takes priority and counts as success.
- Undefined: REQ waits indefinitely, no counter is built, and timeout_err is tied to 0.

Structure
REQ-031 Package mem_if_pkg holds the state enum, the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the TIMEOUT_CYC default.
REQ-032 Sub-module mem_lane_align is combinational. It generates mem_be, replicates store data, and extracts and extends load data. data_mem_if contains only the FSM and the registers.

Verification
REQ-033 LB, addr=0x1003, mem_rdata=0x11223380, ack at cycle 3 -> mem_be=0001, done at cycle 4, rdata=0xFFFFFF80.
REQ-034 LHU, addr=0x2002, mem_rdata=0xAAAA8001 -> mem_be=0011, rdata=0x00008001.
REQ-035 SB, addr=0x10, wdata=0x000000A5 -> mem_we=1, mem_be=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x10.
REQ-036 LW, addr=0x6 -> no mem_req, done at cycle 1 with addr_err=1, rdata unchanged.
REQ-037 MEM_TIMEOUT_EN defined, TIMEOUT_CYC=4, no ack -> mem_req high for 4 cycles, then done with timeout_err=1.
REQ-038 Reset asserted in REQ -> mem_req falls with no clock edge; start after release completes normally; start pulsed while busy is ignored.
